// File: rtl/ysyx_22050039_ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel,
// decode-side instruction handshake, PC redirect and fault status.
// The fetch unit takes the master view; memory and decode take the slave view.
interface ysyx_22050039_ifu_fetch_if #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
);
    // instruction memory request
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_req_addr;
    // instruction memory response (single-cycle pulse, never stalled)
    logic                imem_rsp_valid;
    logic [INST_LEN-1:0] imem_rsp_data;
    // decode handshake
    logic                inst_valid;
    logic                inst_ready;
    logic [INST_LEN-1:0] inst;
    logic [XLEN-1:0]     inst_pc;
    // redirect from decode
    logic                pc_wen;
    logic [XLEN-1:0]     pc_wdata;
    // sticky misaligned-redirect flag
    logic                fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  pc_wen, pc_wdata,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output pc_wen, pc_wdata,
        input  fetch_fault
    );
endinterface

// File: rtl/ysyx_22050039_ifu_fetch.sv
// Instruction fetch stage. Owns the architectural PC, keeps at most one
// instruction-memory request in flight, registers the returned word and
// offers it to decode with valid/ready. Redirects from decode replace the PC
// and squash a stale in-flight fetch via the drop flag; a misaligned redirect
// parks the stage in HALT with a sticky fault until reset.
module ysyx_22050039_ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter int              INST_LEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_22050039_ifu_fetch_if.master      bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // presenting a request to memory
        S_WAIT = 2'd1,  // request accepted, waiting for the response pulse
        S_HOLD = 2'd2,  // instruction offered to decode
        S_HALT = 2'd3   // stopped after a misaligned redirect
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [INST_LEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0]     inst_pc_q, inst_pc_d;
    logic                inst_valid_q, inst_valid_d;
    logic                drop_q, drop_d;
    logic                fault_q, fault_d;

    logic                req_fire;
    logic                misaligned;

    // A request is accepted only while presenting it; only word-aligned
    // targets are legal redirects.
    assign req_fire   = (state_q == S_REQ) && bus.imem_req_ready;
    assign misaligned = bus.pc_wen && (bus.pc_wdata[1:0] != 2'b00);

    // Next-state and datapath selection for the fetch FSM.
    // NOTE: every signal gets its hold value first so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        drop_d    = drop_q;
        fault_d   = fault_q;

        if (misaligned) begin
            // A bad target stops fetching for good; any response still owed
            // by memory must be swallowed rather than decoded.
            pc_d    = bus.pc_wdata;
            fault_d = 1'b1;
            state_d = S_HALT;
            if ((state_q == S_WAIT) || req_fire) begin
                drop_d = 1'b1;
            end else if ((state_q == S_HALT) && bus.imem_rsp_valid) begin
                drop_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    // Before the handshake the address may still change freely;
                    // a redirect coinciding with the handshake orphans the
                    // request just issued, so its response gets dropped.
                    if (bus.pc_wen) begin
                        pc_d = bus.pc_wdata;
                    end
                    if (req_fire) begin
                        state_d = S_WAIT;
                        drop_d  = bus.pc_wen;
                    end
                end
                S_WAIT: begin
                    if (bus.pc_wen) begin
                        pc_d = bus.pc_wdata;
                        if (bus.imem_rsp_valid) begin
                            // Stale word arrives with the redirect: discard now.
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            drop_d  = 1'b1;
                        end
                    end else if (bus.imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_d    = bus.imem_rsp_data;
                            inst_pc_d = pc_q;
                            state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Redirect wins over the sequential increment.
                    if (bus.pc_wen) begin
                        pc_d    = bus.pc_wdata;
                        state_d = S_REQ;
                    end else if (bus.inst_ready) begin
                        pc_d    = pc_q + XLEN'(4);
                        state_d = S_REQ;
                    end
                end
                S_HALT: begin
                    if (bus.imem_rsp_valid) begin
                        drop_d = 1'b0;
                    end
                end
            endcase
        end

        inst_valid_d = (state_d == S_HOLD);
    end

    // State and datapath registers with asynchronous active-low reset.
    // NOTE: non-blocking assignments keep every flop sampling the values
    // from before this edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            drop_q       <= drop_d;
            fault_q      <= fault_d;
        end
    end

    // The request strobe decodes the state directly, so it is high in reset.
    assign bus.imem_req_valid = (state_q == S_REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.fetch_fault    = fault_q;

endmodule
